ecc_bank_scrubber: RTL and testbench

- Sits between a single-port interconnect master and a 1-cycle-latency SRAM bank that stores 39-bit Hsiao SECDED codewords (32 data bits, 7 check bits).
- Interconnect traffic passes through unchanged and always has priority.
- When triggered, the block uses idle bank cycles to walk the bank, read and decode each word, and write back single-bit-corrected codewords.
- Contains its own Hsiao (39,32) encoder and decoder.

---
 rtl/ecc_bank_scrubber.sv | 178 +++++++++++++++++
 tb/tb_ecc_bank_scrubber.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_bank_scrubber.sv
// Background SECDED scrubber for a 1-cycle SRAM bank with Hsiao (39,32) codec.
// Define ECC_SCRUB_STATS_EN to add saturating fix/uncorrectable event counters.
module ecc_bank_scrubber #(
  parameter int BankSize = 256,
  parameter int DataWidth = 39,
  localparam int AddrWidth = $clog2(BankSize)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 scrub_trigger_i,
  output logic                 bit_corrected_o,
  output logic                 uncorrectable_o,
  input  logic                 intc_req_i,
  input  logic                 intc_we_i,
  input  logic [AddrWidth-1:0] intc_add_i,
  input  logic [DataWidth-1:0] intc_wdata_i,
  output logic [DataWidth-1:0] intc_rdata_o,
  output logic                 bank_req_o,
  output logic                 bank_we_o,
  output logic [AddrWidth-1:0] bank_add_o,
  output logic [DataWidth-1:0] bank_wdata_o,
  input  logic [DataWidth-1:0] bank_rdata_i
`ifdef ECC_SCRUB_STATS_EN
  ,
  output logic [15:0]          fix_count_o,
  output logic [15:0]          uncorrectable_count_o
`endif
);

  if (DataWidth != 39) begin : g_width_check
    $error("ecc_bank_scrubber supports only DataWidth = 39");
  end

  // Data columns: first 32 weight-3 values, column 31 first.
  localparam logic [223:0] Cols = {
    7'h62, 7'h61, 7'h58, 7'h54, 7'h52, 7'h51, 7'h4C, 7'h4A,
    7'h49, 7'h46, 7'h45, 7'h43, 7'h38, 7'h34, 7'h32, 7'h31,
    7'h2C, 7'h2A, 7'h29, 7'h26, 7'h25, 7'h23, 7'h1C, 7'h1A,
    7'h19, 7'h16, 7'h15, 7'h13, 7'h0E, 7'h0D, 7'h0B, 7'h07
  };

  function automatic logic [38:0] encode(input logic [31:0] d);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      if (d[i]) c = c ^ Cols[i*7 +: 7];
    end
    return {c, d};
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    READ,
    FIX
  } state_t;

  state_t               state, state_n;
  logic [AddrWidth-1:0] scrub_addr, addr_n, addr_inc;
  logic [38:0]          fix_q, fix_n;
  logic [6:0]           syn;
  logic [31:0]          corr;
  logic                 single, multi;
  logic                 s_req, s_we;
  logic                 bc_raw, unc_raw;

  always_comb begin
    syn    = bank_rdata_i[38:32];
    corr   = bank_rdata_i[31:0];
    single = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (bank_rdata_i[i]) syn = syn ^ Cols[i*7 +: 7];
    end
    for (int i = 0; i < 32; i++) begin
      if (syn == Cols[i*7 +: 7]) begin
        corr[i] = ~corr[i];
        single  = 1'b1;
      end
    end
    for (int k = 0; k < 7; k++) begin
      if (syn == (7'd1 << k)) single = 1'b1;
    end
    multi = (syn != '0) && !single;
  end

  assign addr_inc = (scrub_addr == AddrWidth'(BankSize - 1))
                  ? '0 : scrub_addr + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      scrub_addr <= '0;
      fix_q      <= '0;
    end else begin
      state      <= state_n;
      scrub_addr <= addr_n;
      fix_q      <= fix_n;
    end
  end

  always_comb begin
    state_n = state;
    addr_n  = scrub_addr;
    fix_n   = fix_q;
    s_req   = 1'b0;
    s_we    = 1'b0;
    bc_raw  = 1'b0;
    unc_raw = 1'b0;
    unique case (state)
      IDLE: begin
        if (scrub_trigger_i && !intc_req_i) begin
          s_req   = 1'b1;
          state_n = READ;
        end
      end
      READ: begin
        if (single) begin
          fix_n   = encode(corr);
          state_n = FIX;
        end else begin
          unc_raw = multi;
          addr_n  = addr_inc;
          state_n = IDLE;
        end
      end
      FIX: begin
        if (!intc_req_i) begin
          s_req   = 1'b1;
          s_we    = 1'b1;
          bc_raw  = 1'b1;
          addr_n  = addr_inc;
          state_n = IDLE;
        end else if (intc_we_i && intc_add_i == scrub_addr) begin
          // Fresh interconnect data supersedes the stale correction.
          addr_n  = addr_inc;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bit_corrected_o = bc_raw && !rst_i;
  assign uncorrectable_o = unc_raw && !rst_i;
  assign intc_rdata_o    = bank_rdata_i;

  always_comb begin
    bank_req_o   = 1'b0;
    bank_we_o    = 1'b0;
    bank_add_o   = '0;
    bank_wdata_o = '0;
    if (intc_req_i) begin
      bank_req_o   = 1'b1;
      bank_we_o    = intc_we_i;
      bank_add_o   = intc_add_i;
      bank_wdata_o = intc_wdata_i;
    end else if (s_req && !rst_i) begin
      bank_req_o   = 1'b1;
      bank_we_o    = s_we;
      bank_add_o   = scrub_addr;
      bank_wdata_o = s_we ? fix_q : '0;
    end
  end

`ifdef ECC_SCRUB_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fix_count_o           <= '0;
      uncorrectable_count_o <= '0;
    end else begin
      if (bit_corrected_o && fix_count_o != 16'hFFFF)
        fix_count_o <= fix_count_o + 16'd1;
      if (uncorrectable_o && uncorrectable_count_o != 16'hFFFF)
        uncorrectable_count_o <= uncorrectable_count_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ecc_bank_scrubber.sv
// Bench for ecc_bank_scrubber: SRAM model plus a transaction scoreboard
// derived from the Hsiao code rules, driven by directed and random steps.
module tb_ecc_bank_scrubber;

  localparam int BS = 5;
  localparam int AW = $clog2(BS);

  logic          clk = 1'b0;
  logic          rst_i;
  logic          scrub_trigger_i;
  logic          bit_corrected_o;
  logic          uncorrectable_o;
  logic          intc_req_i;
  logic          intc_we_i;
  logic [AW-1:0] intc_add_i;
  logic [38:0]   intc_wdata_i;
  logic [38:0]   intc_rdata_o;
  logic          bank_req_o;
  logic          bank_we_o;
  logic [AW-1:0] bank_add_o;
  logic [38:0]   bank_wdata_o;
  logic [38:0]   bank_rdata_i;
`ifdef ECC_SCRUB_STATS_EN
  logic [15:0]   fix_count_o;
  logic [15:0]   uncorrectable_count_o;
  int            exp_fix_cnt;
  int            exp_unc_cnt;
`endif

  always #5 clk = ~clk;

  ecc_bank_scrubber #(
    .BankSize (BS),
    .DataWidth(39)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .scrub_trigger_i(scrub_trigger_i),
    .bit_corrected_o(bit_corrected_o),
    .uncorrectable_o(uncorrectable_o),
    .intc_req_i     (intc_req_i),
    .intc_we_i      (intc_we_i),
    .intc_add_i     (intc_add_i),
    .intc_wdata_i   (intc_wdata_i),
    .intc_rdata_o   (intc_rdata_o),
    .bank_req_o     (bank_req_o),
    .bank_we_o      (bank_we_o),
    .bank_add_o     (bank_add_o),
    .bank_wdata_o   (bank_wdata_o),
    .bank_rdata_i   (bank_rdata_i)
`ifdef ECC_SCRUB_STATS_EN
    ,
    .fix_count_o          (fix_count_o),
    .uncorrectable_count_o(uncorrectable_count_o)
`endif
  );

  int            vectors = 0;
  int            miscompares = 0;
  logic [6:0]    col[32];
  logic [38:0]   mem[BS];
  int            pend;
  logic [AW-1:0] exp_addr;
  logic [38:0]   pend_fix;
  logic [AW-1:0] rd_log[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [38:0] enc(input logic [31:0] d);
    logic [6:0] c = '0;
    for (int i = 0; i < 32; i++) if (d[i]) c ^= col[i];
    return {c, d};
  endfunction

  // kind: 0 clean, 1 single error (cd = corrected data), 2 uncorrectable
  task automatic decode(input logic [38:0] w, output int kind,
                        output logic [31:0] cd);
    logic [6:0] s = w[38:32];
    for (int i = 0; i < 32; i++) if (w[i]) s ^= col[i];
    cd = w[31:0];
    kind = (s == 7'd0) ? 0 : 2;
    for (int i = 0; i < 32; i++)
      if (s == col[i]) begin cd[i] = ~cd[i]; kind = 1; end
    for (int k = 0; k < 7; k++) if (s == (7'd1 << k)) kind = 1;
  endtask

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] a);
    return (int'(a) == BS - 1) ? '0 : a + 1'b1;
  endfunction

  task automatic step(input logic req, input logic we,
                      input logic [AW-1:0] add, input logic [38:0] wd,
                      input logic trig, input logic rst);
    logic e_req, e_we, e_bc, e_unc, s_req, s_we;
    logic [AW-1:0] e_add, s_add, addr_n;
    logic [38:0] e_wd, s_wd;
    logic [31:0] cd;
    int kind, pend_n;
    intc_req_i = req; intc_we_i = we; intc_add_i = add;
    intc_wdata_i = wd; scrub_trigger_i = trig; rst_i = rst;
    @(negedge clk);
    e_req = req; e_we = we; e_add = add; e_wd = wd;
    e_bc = 1'b0; e_unc = 1'b0;
    pend_n = pend; addr_n = exp_addr;
    if (rst) begin
      pend_n = 0; addr_n = '0;
    end else if (pend == 0) begin
      if (trig && !req) begin
        e_req = 1'b1; e_we = 1'b0; e_add = exp_addr;
        pend_n = 1; rd_log.push_back(exp_addr);
      end
    end else if (pend == 1) begin
      decode(bank_rdata_i, kind, cd);
      if (kind == 1) begin
        pend_fix = enc(cd); pend_n = 2;
      end else begin
        e_unc = (kind == 2); pend_n = 0; addr_n = nxt(exp_addr);
      end
    end else if (!req) begin
      e_req = 1'b1; e_we = 1'b1; e_add = exp_addr; e_wd = pend_fix;
      e_bc = 1'b1; pend_n = 0; addr_n = nxt(exp_addr);
    end else if (we && add == exp_addr) begin
      pend_n = 0; addr_n = nxt(exp_addr);
    end
    chk("bank_req", 64'(bank_req_o), 64'(e_req));
    if (e_req) begin
      chk("bank_we", 64'(bank_we_o), 64'(e_we));
      chk("bank_add", 64'(bank_add_o), 64'(e_add));
      if (e_we) chk("bank_wdata", 64'(bank_wdata_o), 64'(e_wd));
    end
    chk("bit_corrected", 64'(bit_corrected_o), 64'(e_bc));
    chk("uncorrectable", 64'(uncorrectable_o), 64'(e_unc));
    chk("intc_rdata", 64'(intc_rdata_o), 64'(bank_rdata_i));
`ifdef ECC_SCRUB_STATS_EN
    chk("fix_count", 64'(fix_count_o), 64'(exp_fix_cnt));
    chk("unc_count", 64'(uncorrectable_count_o), 64'(exp_unc_cnt));
    if (rst) begin
      exp_fix_cnt = 0; exp_unc_cnt = 0;
    end else begin
      if (e_bc && exp_fix_cnt < 65535) exp_fix_cnt++;
      if (e_unc && exp_unc_cnt < 65535) exp_unc_cnt++;
    end
`endif
    s_req = bank_req_o; s_we = bank_we_o;
    s_add = bank_add_o; s_wd = bank_wdata_o;
    @(posedge clk);
    #1;
    if (s_req && int'(s_add) < BS) begin
      if (s_we) mem[s_add] = s_wd;
      else bank_rdata_i = mem[s_add];
    end
    pend = pend_n; exp_addr = addr_n;
  endtask

  task automatic idle(input logic trig);
    step(1'b0, 1'b0, '0, '0, trig, 1'b0);
  endtask

  initial begin
    int k;
    logic [38:0] w;
    k = 0;
    for (int v = 0; v < 128; v++)
      if ($countones(v) == 3 && k < 32) begin
        col[k] = 7'(v); k++;
      end
    for (int i = 0; i < BS; i++) mem[i] = enc(32'd0);
    bank_rdata_i = '0;
    pend = 0; exp_addr = '0; pend_fix = '0;
`ifdef ECC_SCRUB_STATS_EN
    exp_fix_cnt = 0; exp_unc_cnt = 0;
`endif
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
    pend = 0; exp_addr = '0;
`ifdef ECC_SCRUB_STATS_EN
    exp_fix_cnt = 0; exp_unc_cnt = 0;
`endif
    idle(1'b0);

    // single fixes, a double error and a check-bit error
    mem[0] = 39'h07_0000_0009;
    mem[1] = 39'h07_0000_0007;
    mem[2] = 39'h0A_0000_0002;
    mem[3] = 39'h00_0000_0010;
    mem[4] = 39'h00_0000_0000;
    rd_log.delete();
    repeat (13) idle(1'b1);
    idle(1'b0);
    chk("fix_addr0", 64'(mem[0]), 64'h07_0000_0001);
    chk("double_kept", 64'(mem[1]), 64'h07_0000_0007);
    chk("fix_check_bit", 64'(mem[2]), 64'h0B_0000_0002);
    chk("fix_zero", 64'(mem[3]), 64'h0);
    chk("first_pass_len", 64'(rd_log.size()), 64'd5);

    // wrap with clean memory
    mem[1] = 39'h07_0000_0007 ^ 39'h6;
    mem[1] = enc(32'd7);
    rd_log.delete();
    repeat (12) idle(1'b1);
    idle(1'b0);
    chk("wrap_count", 64'(rd_log.size()), 64'd6);
    for (int i = 0; i < 6 && i < rd_log.size(); i++)
      chk("wrap_addr", 64'(rd_log[i]), 64'(i % BS));

    // priority: continuous interconnect traffic blocks scrubbing
    rd_log.delete();
    repeat (6)
      step(1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, BS - 1)),
           enc($urandom), 1'b1, 1'b0);
    chk("no_scrub_under_load", 64'(rd_log.size()), 64'd0);
    idle(1'b0);

    // pending fix dropped by an interconnect write to the same word
    mem[exp_addr] = enc(32'h1234_5678) ^ 39'h1;
    k = int'(exp_addr);
    idle(1'b1);
    idle(1'b0);
    step(1'b1, 1'b0, AW'((k + 1) % BS), '0, 1'b0, 1'b0);
    step(1'b1, 1'b1, AW'(k), enc(32'd9), 1'b1, 1'b0);
    idle(1'b0);
    chk("drop_fix", 64'(mem[k]), 64'(enc(32'd9)));

    // reset while a fix is pending
    k = int'(exp_addr);
    w = enc(32'hCAFE_0001) ^ (39'h1 << 20);
    mem[k] = w;
    idle(1'b1);
    idle(1'b1);
    step(1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
    idle(1'b0);
    chk("reset_no_write", 64'(mem[k]), 64'(w));
    rd_log.delete();
    idle(1'b1);
    chk("reset_addr0", 64'(rd_log.size() > 0 ? rd_log[0] : AW'(7)), 64'd0);
    idle(1'b0);

    // randomized traffic, error injection and occasional reset
    for (int c = 0; c < 800; c++) begin
      int f1, f2, nf;
      w = enc($urandom);
      nf = $urandom_range(0, 3);
      f1 = $urandom_range(0, 38);
      f2 = (f1 + $urandom_range(1, 38)) % 39;
      if (nf >= 1) w[f1] = ~w[f1];
      if (nf == 2) w[f2] = ~w[f2];
      step($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
           AW'($urandom_range(0, BS - 1)), w,
           $urandom_range(0, 7) != 0, $urandom_range(0, 199) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
